store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  MEM-stage store buffer between the EX/MEM pipeline register and datamemory.
//  - Posts stores (SB/SH/SW) into a small in-order FIFO.
//  - Drains the FIFO to datamemory on cycles when no load uses the memory port.
//  - Loads pass straight through to datamemory.
//  - Conflicting loads either stall or, when STORE_FWD_EN is defined, get
//    word data forwarded from the buffer.
// PARAMETERS
//  DEPTH       4   buffer entries (power of 2, >=2)
//  DM_ADDRESS  9   datamemory byte-address width
//  DATA_W      32  data width
// PORTS
//  clk         in   1           clock, all state on rising edge
//  reset       in   1           synchronous, active-high
//  req_valid   in   1           MEM-stage request present
//  req_write   in   1           1=store, 0=load
//  req_addr    in   DM_ADDRESS  byte address (ALU result LSBs)
//  req_wdata   in   DATA_W      store data (rs2)
//  req_funct3  in   3           instr[14:12]
//  drain_req   in   1           fence: stall new requests until buffer empty
//  stall       out  1           hold MEM stage and upstream this cycle
//  ld_data     out  DATA_W      load result, valid when req_valid&!req_write&!stall
//  empty       out  1           no valid entries
//  dm_MemRead  out  1           to datamemory MemRead
//  dm_MemWrite out  1           to datamemory MemWrite
//  dm_a        out  DM_ADDRESS  to datamemory a
//  dm_wd       out  DATA_W      to datamemory wd
//  dm_Funct3   out  3           to datamemory Funct3
//  dm_rd       in   DATA_W      from datamemory rd
// BEHAVIOUR
//  Reset
//  - head=tail=count=0, all valid bits 0, entries discarded (not drained).
//  - empty=1, stall=0, dm_MemRead=dm_MemWrite=0.
//  - Reset mid-drain drops all pending stores.
//  Entry
//  - {addr, wdata, funct3} plus a 4-bit byte mask from funct3/addr[1:0]:
//    SB one byte; SH 0011 (off 0/1) or 1100 (off 2/3); SW and other 1111.
//  Store request
//  - Enqueue at tail when count<DEPTH; stall=0; no memory access that cycle.
//  - Full: stall=1. The head drains in the same cycle; the store is accepted
//    on the next cycle. No simultaneous enqueue while full.
//  Load request, overlap check
//  - Overlap: a valid entry with the same word address (addr[8:2]) and a
//    nonzero AND of byte masks. The youngest overlapping entry governs.
//  - No overlap: dm_MemRead=1, dm_a/dm_Funct3=req; ld_data=dm_rd this cycle;
//    no drain that cycle (load has port priority).
//  - Overlap: stall=1 and the head drains each cycle until no overlap remains.
//  Drain
//  - Condition: any cycle with count>0 and the port not used by a load.
//  - dm_MemWrite=1, dm_a/dm_wd/dm_Funct3 = head entry; head++, count--.
//  - One entry per cycle, in program order.
//  Pointers
//  - log2(DEPTH) bits, wrap modulo DEPTH; full/empty from count.
//  drain_req
//  - stall=1 while count>0 (draining continues); released the cycle empty=1.
//  Idle
//  - req_valid=0 with count>0: drain.
//  - req_valid=0 with count=0: all dm_* strobes 0.
// CONFIGURATION
//  STORE_FWD_EN defined
//  - A load whose youngest overlapping entry is SW forwards: stall=0,
//    dm_MemRead=0, drain proceeds that cycle.
//  - ld_data = entry wdata, then per load funct3:
//    LW whole word; LB/LBU low byte; LH/LHU low half;
//    sign- or zero-extended per funct3.
//  - Other overlaps stall as above.
//  STORE_FWD_EN undefined
//  - Every overlap stalls until drained.
// STRUCTURE
//  Package sb_pkg
//  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
//  - sb_entry_t struct.
//  - function byte_mask(funct3, off).
//  Sub-module sb_match
//  - Combinational youngest-overlap search: returns hit, idx, is_sw.
//  - Lives in the same file.
// TESTING
//  1. Reset, then SW @0x10=0xDEADBEEF with no loads
//     -> empty=0 after edge; next cycle dm_MemWrite=1, dm_a=0x10; then empty=1.
//  2. 5 back-to-back SW, DEPTH=4
//     -> stall=1 on the 5th only; dm_MemWrite that cycle; 5th accepted next cycle.
//  3. SB @0x21=0xAA buffered, then LW @0x20, fwd off
//     -> stall until drained (1 cycle); then dm_MemRead=1, ld_data=dm_rd.
//  4. STORE_FWD_EN: SW @0x40=0x000080FF, then LB @0x40
//     -> stall=0, ld_data=0xFFFFFFFF; LBU -> 0x000000FF; dm_MemRead=0.
//  5. Load to non-overlapping word with 2 entries pending
//     -> no stall, dm_MemRead=1, no dm_MemWrite that cycle; drains resume after.
//  6. 3 entries pending, reset pulse
//     -> empty=1, no dm_MemWrite afterwards; drain_req with empty buffer -> stall=0.

Source files
------------

// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sb_pkg
// Description : Shared definitions for the MEM-stage store buffer: RISC-V
//               load/store funct3 encodings, the buffered-entry control
//               struct and the byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    // funct3 encodings (instr[14:12]) for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Per-entry control fields. Address and data live in parallel arrays
    // sized by the module parameters, so they are not part of this struct.
    typedef struct packed {
        logic [2:0] funct3;
        logic [3:0] mask;
    } sb_entry_t;

    // Byte lanes touched by an access. Only funct3[1:0] matters, so the
    // unsigned load variants (LBU/LHU) map to the same lanes as LB/LH.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3,
                                             input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   byte_mask = 4'b0001 << off;
            2'b01:   byte_mask = off[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

endpackage : sb_pkg
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer (with helper sub-module sb_match)
// Description : MEM-stage store buffer between the EX/MEM register and
//               datamemory. Stores are posted into an in-order FIFO and
//               drained one per cycle whenever no load owns the memory port.
//               Loads pass straight through unless they overlap a buffered
//               store, in which case they stall until the overlap drains.
//               Optional macro STORE_FWD_EN: a load whose youngest overlapping
//               entry is a full-word store gets its data forwarded instead.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               req_*                - MEM-stage request (valid/write/addr/
//                                      wdata/funct3)
//               drain_req            - fence: hold requests until empty
//               stall                - hold MEM stage and upstream
//               ld_data              - load result
//               empty                - buffer holds no entries
//               dm_*                 - datamemory port (MemRead/MemWrite/
//                                      a/wd/Funct3 out, rd in)
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// sb_match: combinational youngest-overlap search. Walks the entries from
// head (oldest) towards tail; each later hit overrides an earlier one, so the
// result is the youngest overlapping entry.
// ----------------------------------------------------------------------------
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WA_W  = 7
) (
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [DEPTH-1:0]           i_valid,
    input  sb_entry_t [DEPTH-1:0]      i_entries,
    input  logic [DEPTH-1:0][WA_W-1:0] i_waddr,
    input  logic [WA_W-1:0]            i_ld_waddr,
    input  logic [3:0]                 i_ld_mask,
    output logic                       o_hit,
    output logic [$clog2(DEPTH)-1:0]   o_idx,
    output logic                       o_is_sw
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] w_i;

    always_comb begin
        o_hit   = 1'b0;
        o_idx   = '0;
        o_is_sw = 1'b0;
        w_i     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_i = i_head + c_PTR_W'(k);
            if (i_valid[w_i] && (i_waddr[w_i] == i_ld_waddr) &&
                ((i_entries[w_i].mask & i_ld_mask) != 4'b0000)) begin
                o_hit   = 1'b1;
                o_idx   = w_i;
                o_is_sw = (i_entries[w_i].funct3 == F3_W);
            end
        end
    end

endmodule : sb_match

module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    input  logic                  drain_req,
    output logic                  stall,
    output logic [DATA_W-1:0]     ld_data,
    output logic                  empty,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
    input  logic [DATA_W-1:0]     dm_rd
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_WA_W  = DM_ADDRESS - 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]                 r_head;
    logic [c_PTR_W-1:0]                 r_tail;
    logic [c_PTR_W:0]                   r_count;
    logic [DEPTH-1:0]                   r_valid;
    sb_entry_t [DEPTH-1:0]              r_entry;
    logic [DEPTH-1:0][DM_ADDRESS-1:0]   r_addr;
    logic [DEPTH-1:0][DATA_W-1:0]       r_wdata;

    // ------------------------------------------------------------------------
    // Request decode and overlap search
    // ------------------------------------------------------------------------
    logic                         w_load;
    logic                         w_store;
    logic                         w_full;
    logic                         w_nonempty;
    logic [3:0]                   w_req_mask;
    logic [DEPTH-1:0][c_WA_W-1:0] w_waddr;
    logic                         w_hit;
    logic [c_PTR_W-1:0]           w_hit_idx;
    logic                         w_hit_is_sw;
    logic                         w_fwd;
    logic                         w_fence_stall;
    logic                         w_ld_port;
    logic                         w_enq;
    logic                         w_drain;
    logic [DATA_W-1:0]            w_fwd_data;

    assign w_load     = req_valid & ~req_write;
    assign w_store    = req_valid &  req_write;
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign w_req_mask = byte_mask(req_funct3, req_addr[1:0]);

    // Word addresses of the buffered entries for the overlap compare
    for (genvar g = 0; g < DEPTH; g++) begin : g_waddr
        assign w_waddr[g] = r_addr[g][DM_ADDRESS-1:2];
    end

    sb_match #(
        .DEPTH (DEPTH),
        .WA_W  (c_WA_W)
    ) u_match (
        .i_head     (r_head),
        .i_valid    (r_valid),
        .i_entries  (r_entry),
        .i_waddr    (w_waddr),
        .i_ld_waddr (req_addr[DM_ADDRESS-1:2]),
        .i_ld_mask  (w_req_mask),
        .o_hit      (w_hit),
        .o_idx      (w_hit_idx),
        .o_is_sw    (w_hit_is_sw)
    );

`ifdef STORE_FWD_EN
    // Only a full-word youngest overlap holds every byte the load could
    // want, so only that case forwards; partial overlaps still stall.
    logic [DATA_W-1:0] w_fwd_word;

    assign w_fwd      = w_load & w_hit & w_hit_is_sw;
    assign w_fwd_word = r_wdata[w_hit_idx];

    always_comb begin
        case (req_funct3)
            F3_B:    w_fwd_data = {{(DATA_W-8){w_fwd_word[7]}},   w_fwd_word[7:0]};
            F3_BU:   w_fwd_data = {{(DATA_W-8){1'b0}},            w_fwd_word[7:0]};
            F3_H:    w_fwd_data = {{(DATA_W-16){w_fwd_word[15]}}, w_fwd_word[15:0]};
            F3_HU:   w_fwd_data = {{(DATA_W-16){1'b0}},           w_fwd_word[15:0]};
            default: w_fwd_data = w_fwd_word;
        endcase
    end
`else
    logic w_unused_fwd;

    assign w_fwd        = 1'b0;
    assign w_fwd_data   = '0;
    assign w_unused_fwd = ^{w_hit_idx, w_hit_is_sw};
`endif

    // A fence blocks every new request (load or store) while entries remain;
    // the drain keeps running underneath it.
    assign w_fence_stall = drain_req & w_nonempty;

    // A load owns the memory port only when it reads datamemory itself
    assign w_ld_port = w_load & ~w_hit & ~w_fence_stall;

    assign w_enq = w_store & ~w_full & ~w_fence_stall;

    // Accepted stores make no memory access that cycle; a store against a
    // full buffer is not accepted, so the head drains to make room.
    assign w_drain = w_nonempty & ~w_ld_port & ~w_enq;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign empty = ~w_nonempty;

    always_comb begin
        stall       = w_fence_stall
                    | (w_store & w_full)
                    | (w_load & w_hit & ~w_fwd);
        ld_data     = w_fwd ? w_fwd_data : dm_rd;
        dm_MemRead  = 1'b0;
        dm_MemWrite = 1'b0;
        dm_a        = '0;
        dm_wd       = '0;
        dm_Funct3   = '0;
        if (w_ld_port) begin
            dm_MemRead = 1'b1;
            dm_a       = req_addr;
            dm_Funct3  = req_funct3;
        end else if (w_drain) begin
            dm_MemWrite = 1'b1;
            dm_a        = r_addr[r_head];
            dm_wd       = r_wdata[r_head];
            dm_Funct3   = r_entry[r_head].funct3;
        end
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entry[r_tail].funct3 <= req_funct3;
            r_entry[r_tail].mask   <= w_req_mask;
            r_addr[r_tail]         <= req_addr;
            r_wdata[r_tail]        <= req_wdata;
        end
    end

endmodule : store_buffer
`default_nettype wire
